// File: rtl/bcd_countdown_ctrl.sv
// N-digit BCD countdown timer: debounced five-key entry, pause/abort, and a
// scanned active-low 7-segment display whose select and segments are registered together.
module bcd_countdown_ctrl #(
   parameter int unsigned DIGITS          = 6,
   parameter int unsigned TICK_CYCLES     = 50000000,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned SCAN_CYCLES     = 1000000,
   parameter int unsigned BLINK_CYCLES    = 25000000
) (
   input  logic                clkin,
   input  logic                rst,
   input  logic                ke,
   input  logic                ku,
   input  logic                kd,
   input  logic                kl,
   input  logic                kr,
   output logic [DIGITS-1:0]   sel,
   output logic [7:0]          led,
   output logic                alarm,
   output logic [2:0]          state_o,
   output logic [4*DIGITS-1:0] digits_o
);

   localparam int unsigned CW = $clog2(DIGITS);
   localparam int unsigned TW = $clog2(TICK_CYCLES + 1);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned SW = $clog2(SCAN_CYCLES + 1);
   localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SET   = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      ALARM = 3'd4
   } state_t;

   // key vector order: 0=ke 1=kd 2=ku 3=kl 4=kr (also the priority order)
   logic [4:0]    raw, sync1, sync2, deb, evt;
   logic [DW-1:0] dcnt [5];
   logic          ev_e, ev_d, ev_u, ev_l, ev_r;

   state_t              state, state_nx;
   logic [4*DIGITS-1:0] value, value_nx, dec_v;
   logic [CW-1:0]       cursor, cursor_nx;
   logic [TW-1:0]       tick, tick_nx;
   logic [3:0]          cur_d, new_d;
   logic                wr_d;

   logic [SW-1:0]       scan_cnt;
   logic [CW-1:0]       scan_idx;
   logic [BW-1:0]       blink_cnt;
   logic                blink_phase;
   logic [3:0]          scan_d;
   logic [DIGITS-1:0]   sel_nx;
   logic [7:0]          led_nx;

   function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
      logic       borrow;
      logic [3:0] d;
      bcd_dec = v;
      borrow  = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) d = 4'd9;
            else begin
               d      = d - 4'd1;
               borrow = 1'b0;
            end
         end
         bcd_dec[4*i +: 4] = d;
      end
   endfunction

   always_comb raw = {kr, kl, ku, kd, ke};

   // event fires on the debounced release edge (0 -> 1)
   always_ff @(posedge clkin) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
         deb   <= '1;
         evt   <= '0;
         for (int unsigned i = 0; i < 5; i++) dcnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int unsigned i = 0; i < 5; i++) begin
            evt[i] <= 1'b0;
            if (sync2[i] == deb[i]) dcnt[i] <= '0;
            else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               dcnt[i] <= '0;
               deb[i]  <= sync2[i];
               evt[i]  <= sync2[i];
            end else dcnt[i] <= dcnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      ev_e = evt[0];
      ev_d = evt[1] & ~evt[0];
      ev_u = evt[2] & ~|evt[1:0];
      ev_l = evt[3] & ~|evt[2:0];
      ev_r = evt[4] & ~|evt[3:0];
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         state  <= IDLE;
         value  <= '0;
         cursor <= CW'(DIGITS - 1);
         tick   <= '0;
      end else begin
         state  <= state_nx;
         value  <= value_nx;
         cursor <= cursor_nx;
         tick   <= tick_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      value_nx  = value;
      cursor_nx = cursor;
      tick_nx   = tick;
      wr_d      = 1'b0;
      cur_d     = '0;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (cursor == CW'(i)) cur_d = value[4*(DIGITS-1-i) +: 4];
      new_d = cur_d;
      dec_v = bcd_dec(value);
      case (state)
         IDLE: if (ev_e) begin
            state_nx  = SET;
            value_nx  = '0;
            cursor_nx = CW'(DIGITS - 1);
         end
         SET: begin
            if (ev_e) begin
               if (value != '0) begin
                  state_nx = RUN;
                  tick_nx  = '0;
               end
            end else if (ev_d) begin
               wr_d  = 1'b1;
               new_d = (cur_d == 4'd0) ? 4'd9 : cur_d - 4'd1;
            end else if (ev_u) begin
               wr_d  = 1'b1;
               new_d = (cur_d == 4'd9) ? 4'd0 : cur_d + 4'd1;
            end else if (ev_l) begin
               cursor_nx = (cursor == '0) ? CW'(DIGITS - 1) : cursor - 1'b1;
            end else if (ev_r) begin
               cursor_nx = (cursor == CW'(DIGITS - 1)) ? '0 : cursor + 1'b1;
            end
         end
         RUN: begin
            if (ev_e) state_nx = PAUSE;
            else if (ev_d) begin
               state_nx = IDLE;
               value_nx = '0;
               tick_nx  = '0;
            end else if (tick == TW'(TICK_CYCLES - 1)) begin
               tick_nx  = '0;
               value_nx = dec_v;
               if (dec_v == '0) state_nx = ALARM;
            end else tick_nx = tick + 1'b1;
         end
         PAUSE: begin
            if (ev_e) state_nx = RUN;
            else if (ev_d) begin
               state_nx = IDLE;
               value_nx = '0;
               tick_nx  = '0;
            end
         end
         ALARM: if (ev_e) state_nx = IDLE;
         default: begin
            state_nx = IDLE;
            value_nx = '0;
         end
      endcase
      for (int unsigned i = 0; i < DIGITS; i++)
         if (wr_d && cursor == CW'(i)) value_nx[4*(DIGITS-1-i) +: 4] = new_d;
   end

   always_comb begin
      state_o  = state;
      alarm    = (state != ALARM);
      digits_o = value;
   end

   always_comb begin
      scan_d = '0;
      sel_nx = '1;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (scan_idx == CW'(i)) begin
            scan_d    = value[4*(DIGITS-1-i) +: 4];
            sel_nx[i] = 1'b0;
         end
      led_nx = 8'hFF;
      case (scan_d)
         4'd0: led_nx = 8'hC0;
         4'd1: led_nx = 8'hF9;
         4'd2: led_nx = 8'hA4;
         4'd3: led_nx = 8'hB0;
         4'd4: led_nx = 8'h99;
         4'd5: led_nx = 8'h92;
         4'd6: led_nx = 8'h82;
         4'd7: led_nx = 8'hF8;
         4'd8: led_nx = 8'h80;
         4'd9: led_nx = 8'h90;
         default: led_nx = 8'hFF;
      endcase
      if ((state == ALARM && blink_phase) ||
          (state == SET && blink_phase && scan_idx == cursor)) led_nx = 8'hFF;
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         scan_cnt    <= '0;
         scan_idx    <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         sel         <= '1;
         led         <= 8'hFF;
      end else begin
         if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == CW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
         end else scan_cnt <= scan_cnt + 1'b1;
         if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else blink_cnt <= blink_cnt + 1'b1;
         sel <= sel_nx;
         led <= led_nx;
      end
   end

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Directed bench for bcd_countdown_ctrl with DIGITS=3 and short timing parameters.
module tb_bcd_countdown_ctrl;

   localparam int K_E = 0, K_D = 1, K_U = 2, K_L = 3, K_R = 4;

   logic        clkin = 1'b0;
   logic        rst   = 1'b1;
   logic        ke = 1'b1, ku = 1'b1, kd = 1'b1, kl = 1'b1, kr = 1'b1;
   logic [2:0]  sel;
   logic [7:0]  led;
   logic        alarm;
   logic [2:0]  state_o;
   logic [11:0] digits_o;

   int passed = 0;
   int total  = 0;

   bcd_countdown_ctrl #(
      .DIGITS(3), .TICK_CYCLES(20), .DEBOUNCE_CYCLES(4),
      .SCAN_CYCLES(2), .BLINK_CYCLES(8)
   ) dut (
      .clkin(clkin), .rst(rst), .ke(ke), .ku(ku), .kd(kd), .kl(kl), .kr(kr),
      .sel(sel), .led(led), .alarm(alarm), .state_o(state_o), .digits_o(digits_o)
   );

   always #5 clkin = ~clkin;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [11:0] to_bcd(input int n);
      return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic set_key(input int k, input logic v);
      case (k)
         K_E: ke = v;
         K_D: kd = v;
         K_U: ku = v;
         K_L: kl = v;
         default: kr = v;
      endcase
   endtask

   task automatic press(input int k);
      set_key(k, 1'b0);
      repeat (8) @(negedge clkin);
      set_key(k, 1'b1);
      repeat (12) @(negedge clkin);
   endtask

   task automatic hold_release(input int k);
      set_key(k, 1'b0);
      repeat (8) @(negedge clkin);
      set_key(k, 1'b1);
   endtask

   task automatic wait_state(input logic [2:0] s, input int lim, output int n);
      n = 0;
      while (state_o !== s && n < lim) begin
         @(negedge clkin);
         n++;
      end
   endtask

   task automatic do_reset();
      @(negedge clkin);
      rst = 1'b1;
      repeat (2) @(negedge clkin);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clkin);
      total++; if (state_o !== 3'd0) $display("FAIL reset_state got %0d exp 0", state_o); else passed++;
      total++; if (digits_o !== 12'h000) $display("FAIL reset_digits got %h exp 000", digits_o); else passed++;
      total++; if (sel !== 3'b111) $display("FAIL reset_sel got %b exp 111", sel); else passed++;
      total++; if (led !== 8'hFF) $display("FAIL reset_led got %h exp FF", led); else passed++;
      total++; if (alarm !== 1'b1) $display("FAIL reset_alarm got %b exp 1", alarm); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_debounce();
      int n;
      ke = 1'b0;
      repeat (2) @(negedge clkin);
      ke = 1'b1;
      repeat (15) @(negedge clkin);
      total++; if (state_o !== 3'd0) $display("FAIL short_pulse got state %0d exp 0", state_o); else passed++;
      ke = 1'b0;
      repeat (10) @(negedge clkin);
      ke = 1'b1;
      total++; if (state_o !== 3'd0) $display("FAIL event_on_press got state %0d exp 0", state_o); else passed++;
      wait_state(3'd1, 30, n);
      total++; if (state_o !== 3'd1) $display("FAIL enter_set got state %0d exp 1", state_o); else passed++;
      total++; if (n < 5 || n > 8) $display("FAIL release_latency got %0d exp 5..8", n); else passed++;
      total++; if (digits_o !== 12'h000) $display("FAIL set_cleared got %h exp 000", digits_o); else passed++;
   endtask

   task automatic test_zero_start();
      press(K_E);
      total++; if (state_o !== 3'd1) $display("FAIL zero_start got state %0d exp 1", state_o); else passed++;
   endtask

   task automatic test_edit();
      repeat (3) press(K_U);
      total++; if (digits_o !== 12'h003) $display("FAIL edit_up3 got %h exp 003", digits_o); else passed++;
      press(K_L);
      press(K_U);
      total++; if (digits_o !== 12'h013) $display("FAIL edit_left_up got %h exp 013", digits_o); else passed++;
      press(K_D);
      total++; if (digits_o !== 12'h003) $display("FAIL edit_down1 got %h exp 003", digits_o); else passed++;
      press(K_D);
      total++; if (digits_o !== 12'h093) $display("FAIL edit_down_wrap got %h exp 093", digits_o); else passed++;
      press(K_R);
      press(K_R);
      press(K_U);
      total++; if (digits_o !== 12'h193) $display("FAIL edit_right_wrap got %h exp 193", digits_o); else passed++;
      press(K_L);
      press(K_U);
      total++; if (digits_o !== 12'h194) $display("FAIL edit_left_wrap got %h exp 194", digits_o); else passed++;
   endtask

   task automatic test_countdown();
      int n, cyc, rem, guard, bad, saw_ff, saw_c0;
      logic [11:0] prev;
      do_reset();
      press(K_E);
      press(K_U);
      press(K_L);
      press(K_U);
      total++; if (digits_o !== 12'h011) $display("FAIL cd_setup got %h exp 011", digits_o); else passed++;
      hold_release(K_E);
      wait_state(3'd2, 30, n);
      total++; if (state_o !== 3'd2) $display("FAIL cd_run got state %0d exp 2", state_o); else passed++;
      rem = 11; cyc = 0; prev = digits_o;
      for (guard = 0; guard < 400 && rem > 0; guard++) begin
         @(negedge clkin);
         cyc++;
         if (digits_o !== prev) begin
            rem--;
            total++; if (digits_o !== to_bcd(rem)) $display("FAIL cd_value got %h exp %h", digits_o, to_bcd(rem)); else passed++;
            total++; if (cyc != 20) $display("FAIL cd_period got %0d exp 20 at %h", cyc, digits_o); else passed++;
            prev = digits_o;
            cyc = 0;
         end
      end
      total++; if (rem != 0) $display("FAIL cd_timeout remaining %0d exp 0", rem); else passed++;
      total++; if (state_o !== 3'd4) $display("FAIL cd_alarm_state got %0d exp 4", state_o); else passed++;
      total++; if (alarm !== 1'b0) $display("FAIL cd_alarm_out got %b exp 0", alarm); else passed++;
      // alarm display: every digit reads 0 or blank
      bad = 0; saw_ff = 0; saw_c0 = 0;
      repeat (24) begin
         @(negedge clkin);
         if (led === 8'hFF) saw_ff++;
         else if (led === 8'hC0) saw_c0++;
         else bad++;
      end
      total++; if (bad != 0 || saw_ff == 0 || saw_c0 == 0)
         $display("FAIL alarm_blink bad=%0d ff=%0d c0=%0d exp 0/>0/>0", bad, saw_ff, saw_c0); else passed++;
      total++; if (alarm !== 1'b0) $display("FAIL alarm_held got %b exp 0", alarm); else passed++;
      press(K_U);
      total++; if (state_o !== 3'd4) $display("FAIL alarm_ignore_ku got state %0d exp 4", state_o); else passed++;
      hold_release(K_E);
      guard = 0;
      while (state_o === 3'd4 && guard < 30) begin
         @(negedge clkin);
         guard++;
      end
      total++; if (state_o !== 3'd0) $display("FAIL alarm_exit got state %0d exp 0", state_o); else passed++;
      total++; if (alarm !== 1'b1) $display("FAIL alarm_exit_out got %b exp 1", alarm); else passed++;
      repeat (12) @(negedge clkin);
   endtask

   task automatic test_pause();
      int n, b, bad, guard;
      press(K_E);
      press(K_D);
      total++; if (digits_o !== 12'h009) $display("FAIL pause_setup got %h exp 009", digits_o); else passed++;
      hold_release(K_E);
      guard = 0;
      while (digits_o !== 12'h007 && guard < 100) begin
         @(negedge clkin);
         guard++;
      end
      hold_release(K_E);
      wait_state(3'd3, 30, n);
      total++; if (state_o !== 3'd3) $display("FAIL pause_enter got state %0d exp 3", state_o); else passed++;
      bad = 0;
      repeat (200) begin
         @(negedge clkin);
         if (digits_o !== 12'h007 || state_o !== 3'd3) bad++;
      end
      total++; if (bad != 0) $display("FAIL pause_hold got %0d bad cycles exp 0", bad); else passed++;
      hold_release(K_E);
      wait_state(3'd2, 30, n);
      total++; if (state_o !== 3'd2) $display("FAIL resume got state %0d exp 2", state_o); else passed++;
      b = 0;
      while (digits_o === 12'h007 && b < 40) begin
         @(negedge clkin);
         b++;
      end
      total++; if (b < 1 || b > 19) $display("FAIL resume_remaining got %0d cycles exp 1..19", b); else passed++;
      total++; if (digits_o !== 12'h006) $display("FAIL resume_value got %h exp 006", digits_o); else passed++;
      hold_release(K_E);
      wait_state(3'd3, 30, n);
      total++; if (state_o !== 3'd3) $display("FAIL pause_again got state %0d exp 3", state_o); else passed++;
      press(K_D);
      total++; if (state_o !== 3'd0) $display("FAIL abort got state %0d exp 0", state_o); else passed++;
      total++; if (alarm !== 1'b1) $display("FAIL abort_alarm got %b exp 1", alarm); else passed++;
      total++; if (digits_o !== 12'h000) $display("FAIL abort_value got %h exp 000", digits_o); else passed++;
   endtask

   task automatic test_priority();
      press(K_E);
      ku = 1'b0; kl = 1'b0;
      repeat (8) @(negedge clkin);
      ku = 1'b1; kl = 1'b1;
      repeat (12) @(negedge clkin);
      total++; if (digits_o !== 12'h001) $display("FAIL prio_up got %h exp 001", digits_o); else passed++;
      press(K_U);
      total++; if (digits_o !== 12'h002) $display("FAIL prio_cursor_kept got %h exp 002", digits_o); else passed++;
   endtask

   task automatic test_scan();
      int idx, pidx, run, first, seq_err, run_err, led_err, saw_blank, saw_code;
      logic [7:0] codes [3];
      logic [2:0] psel;
      press(K_L);
      press(K_U);
      press(K_L);
      repeat (3) press(K_U);
      total++; if (digits_o !== 12'h312) $display("FAIL scan_setup got %h exp 312", digits_o); else passed++;
      codes[0] = 8'hB0; codes[1] = 8'hF9; codes[2] = 8'hA4;
      seq_err = 0; run_err = 0; led_err = 0; saw_blank = 0; saw_code = 0;
      first = 1; run = 0; pidx = -1; psel = 3'b111;
      repeat (48) begin
         @(negedge clkin);
         case (sel)
            3'b110: idx = 0;
            3'b101: idx = 1;
            3'b011: idx = 2;
            default: idx = -1;
         endcase
         if (idx < 0) seq_err++;
         else if (idx == 0) begin
            if (led === 8'hFF) saw_blank++;
            else if (led === codes[0]) saw_code++;
            else led_err++;
         end else if (led !== codes[idx]) led_err++;
         if (sel !== psel) begin
            if (pidx >= 0) begin
               if (idx != (pidx + 1) % 3) seq_err++;
               if (!first && run != 2) run_err++;
               first = 0;
            end
            run = 1;
            pidx = idx;
            psel = sel;
         end else run++;
      end
      total++; if (seq_err != 0) $display("FAIL scan_order got %0d errors exp 0", seq_err); else passed++;
      total++; if (run_err != 0) $display("FAIL scan_hold got %0d errors exp 0", run_err); else passed++;
      total++; if (led_err != 0) $display("FAIL scan_led got %0d errors exp 0", led_err); else passed++;
      total++; if (saw_blank == 0 || saw_code == 0)
         $display("FAIL cursor_blink blank=%0d code=%0d exp both >0", saw_blank, saw_code); else passed++;
   endtask

   task automatic test_reset_mid_run();
      int n;
      hold_release(K_E);
      wait_state(3'd2, 30, n);
      repeat (5) @(negedge clkin);
      total++; if (state_o !== 3'd2) $display("FAIL mid_run got state %0d exp 2", state_o); else passed++;
      rst = 1'b1;
      @(negedge clkin);
      total++; if (state_o !== 3'd0) $display("FAIL mid_rst_state got %0d exp 0", state_o); else passed++;
      total++; if (digits_o !== 12'h000) $display("FAIL mid_rst_digits got %h exp 000", digits_o); else passed++;
      total++; if (sel !== 3'b111) $display("FAIL mid_rst_sel got %b exp 111", sel); else passed++;
      total++; if (led !== 8'hFF) $display("FAIL mid_rst_led got %h exp FF", led); else passed++;
      rst = 1'b0;
      hold_release(K_E);
      repeat (2) @(negedge clkin);
      rst = 1'b1;
      @(negedge clkin);
      rst = 1'b0;
      repeat (15) @(negedge clkin);
      total++; if (state_o !== 3'd0) $display("FAIL pending_event got state %0d exp 0", state_o); else passed++;
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_zero_start();
      test_edit();
      test_countdown();
      test_pause();
      test_priority();
      test_scan();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bcd_countdown_ctrl.md
Name: bcd_countdown_ctrl

Overview:
Parametrised N-digit BCD countdown timer with five-button entry, debounce, pause/resume/abort and a multiplexed active-low 7-segment driver.
- Generalises the fixed 6-digit countdown.
- Adds pause, abort, zero-start rejection, key priority and scan-aligned segment output.
- Sits between board buttons/clock and the display/buzzer pins.

Parameters:
DIGITS, 6, number of BCD digits (2..8)
TICK_CYCLES, 50000000, clkin cycles per one-unit decrement
DEBOUNCE_CYCLES, 1000000, cycles a key level must be stable to be accepted
SCAN_CYCLES, 1000000, cycles each digit is enabled during scan
BLINK_CYCLES, 25000000, cycles per blink phase toggle

Ports:
clkin  in  1  system clock
rst  in  1  synchronous, active-high reset
ke  in  1  enter key, raw, active-low
ku  in  1  up key, raw, active-low
kd  in  1  down/abort key, raw, active-low
kl  in  1  cursor-left key, raw, active-low
kr  in  1  cursor-right key, raw, active-low
sel  out  DIGITS  digit enables, active-low, one-hot; sel[0] = most significant digit
led  out  8  segments {dp,g..a}, active-low
alarm  out  1  buzzer, active-low
state_o  out  3  current state encoding
digits_o  out  4*DIGITS  current BCD value, MSD in top nibble

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state IDLE; value 0; cursor DIGITS-1.
  - alarm=1, sel=all ones, led=8'hFF.
  - All counters 0; blink_phase 0.
  - Debounced key levels 1 (released).
- Key path:
  - Each key passes through a 2-flop synchroniser.
  - Debounce counter clears whenever the synced level equals the debounced level.
  - When the synced level has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level updates.
  - A one-cycle event fires on the debounced 0->1 edge, i.e. on release.
  - Pulses shorter than DEBOUNCE_CYCLES produce no event.
- Simultaneous events in one cycle: priority ke > kd > ku > kl > kr. Lower-priority events are discarded.
- States (state_o): IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4.
- IDLE:
  - Value shown as all zeros.
  - ke -> SET, value cleared, cursor=DIGITS-1.
  - Other keys ignored.
- SET:
  - ku: cursor digit +1, 9 wraps to 0.
  - kd: cursor digit -1, 0 wraps to 9.
  - kl: cursor -1, 0 wraps to DIGITS-1.
  - kr: cursor +1, DIGITS-1 wraps to 0.
  - No carry or borrow between digits during edit.
  - ke with value==0: ignored, stay SET. Otherwise -> RUN with tick counter cleared.
- RUN:
  - Tick counter counts 0..TICK_CYCLES-1.
  - On wrap, value decrements by 1 as a full BCD number (borrow: digit 0 -> 9, borrow to next-higher digit).
  - If the decrement result is 0, go to ALARM in the same cycle the value becomes 0.
  - ke -> PAUSE; tick counter holds its count.
  - kd -> IDLE.
- PAUSE:
  - Value and tick counter frozen.
  - ke -> RUN, resuming from the held tick count.
  - kd -> IDLE.
- ALARM:
  - alarm=0 while in ALARM; value 0.
  - ke -> IDLE with alarm=1 on the transition cycle.
  - Other keys ignored.
- Display:
  - Scan counter advances the digit index every SCAN_CYCLES, 0..DIGITS-1 wrapping.
  - sel and led are registered together, so led always matches the digit enabled in the same cycle.
  - Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
  - No leading-zero suppression.
  - blink_phase toggles every BLINK_CYCLES.
  - In SET, the cursor digit is blank while blink_phase=1.
  - In ALARM, all digits are blank while blink_phase=1.
- Reset mid-operation: all reset values apply on the next edge. No pending key event survives reset.

Test Plan:
(Use DIGITS=3, TICK_CYCLES=20, DEBOUNCE_CYCLES=4, SCAN_CYCLES=2, BLINK_CYCLES=8.)
- Debounce and entry:
  - Stimulus: after reset, ke low 2 cycles then high.
  - Response: state_o stays 0.
  - Stimulus: ke low 10 cycles then high.
  - Response: ~6 cycles after release, state_o=1, digits_o=12'h000.
- Edit:
  - Stimulus: ku x3, kl, ku x1; then kd x2 at cursor 1.
  - Response: digits_o=12'h013 after the first five presses; after kd x2, 12'h093 (wrap 0 -> 9 at cursor 1 after one kd).
  - Stimulus: kr from cursor 2.
  - Response: cursor 0.
- Start and countdown:
  - Stimulus: ke in SET with value 000.
  - Response: stays SET.
  - Stimulus: set value 011, press ke.
  - Response: state RUN; decrements every 20 cycles; 010 -> 009 borrow observed; after 11 ticks state ALARM, alarm=0, digits_o=0.
- Pause and abort:
  - Stimulus: ke during RUN at 007.
  - Response: PAUSE, value holds 007 for 200 cycles.
  - Stimulus: ke.
  - Response: RUN resumes; next decrement within the remaining tick count.
  - Stimulus: kd in PAUSE.
  - Response: IDLE, alarm stays 1.
- Priority and ALARM exit:
  - Stimulus: ku and kl released on the same cycle in SET.
  - Response: only the digit increments.
  - Stimulus: ke in ALARM.
  - Response: IDLE, alarm=1.
  - Stimulus: rst pulse mid-RUN.
  - Response: next cycle state 0, digits_o 0, sel=3'b111, led=FF.
- Scan:
  - Stimulus: run in SET.
  - Response: sel sequence 110, 101, 011, each held 2 cycles, with led code of that digit in the same cycle; cursor digit reads FF while blink_phase=1.
